// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the 9-bit CPU sequencer: FSM states, opcodes, widths.
// Opcode is ir[8:6]; only SAVE is inspected by the sequencer itself.
package cpu_sequencer_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int IR_W_DEF  = 9;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_JMPZ = 3'd5;
  localparam logic [2:0] OP_LOAD = 3'd6;
  localparam logic [2:0] OP_SAVE = 3'd7;

  function automatic logic is_save(input logic [2:0] op);
    return op == OP_SAVE;
  endfunction

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter: async reset to RESET_PC, load has priority over +1.
// Ports: clk, rst_n, load, inc, load_val[PC_W], pc[PC_W].
module cpu_pc_reg #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch into IR, gate decoder controls into strobes.
// Ports: run, imem req/addr/valid/rdata, ir, dec_*, alu_zero, jump_target,
//        dmem req/we/ack, rf_we, pc, busy, retired.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              IR_W     = IR_W_DEF,
  parameter int              CNT_W    = CNT_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [IR_W-1:0]  imem_rdata,
  output logic [IR_W-1:0]  ir,
  input  logic             dec_write_rf,
  input  logic             dec_jump_en,
  input  logic             dec_mem_sel,
  input  logic             alu_zero,
  input  logic [PC_W-1:0]  jump_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic [PC_W-1:0]  pc,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);

  state_t     state;
  state_t     next_b;
  logic [2:0] op;
  logic       retire;
  logic       pc_load;
  logic       pc_inc;

  assign op     = ir[IR_W-1 -: 3];
  assign next_b = run ? ST_FETCH : ST_IDLE;

  // Retire cycle = the cycle an instruction commits its PC update.
  always_comb begin
    retire  = 1'b0;
    pc_load = 1'b0;
    case (state)
      ST_EXEC: begin
        if (dec_jump_en) begin
          retire  = 1'b1;
          pc_load = alu_zero;
        end else if (!dec_mem_sel && !dec_write_rf) begin
          retire  = 1'b1;
        end
      end
      ST_MEM:  retire = dmem_ack && is_save(op);
      ST_WB:   retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  assign pc_inc = retire && !pc_load;

  cpu_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (jump_target),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      case (state)
        ST_IDLE: if (run) state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_rdata;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          if (dec_jump_en)       state <= next_b;
          else if (dec_mem_sel)  state <= ST_MEM;
          else if (dec_write_rf) state <= ST_WB;
          else                   state <= next_b;
        end
        ST_MEM: begin
          if (dmem_ack)
            state <= is_save(op) ? next_b : ST_WB;
        end
        ST_WB:   state <= next_b;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decodes of the state register; reset drops them with state.
  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (state == ST_MEM);
  assign dmem_we   = (state == ST_MEM) && is_save(op);
  assign rf_we     = (state == ST_WB);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer; second instance uses a 4-bit counter
// so the retired-count wrap is reachable in a short run.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       imem_valid;
  logic [8:0] imem_rdata;
  logic       dec_write_rf;
  logic       dec_jump_en;
  logic       dec_mem_sel;
  logic       alu_zero;
  logic [7:0] jump_target;
  logic       dmem_ack;

  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [8:0]  ir;
  logic        dmem_req;
  logic        dmem_we;
  logic        rf_we;
  logic [7:0]  pc;
  logic        busy;
  logic [15:0] retired;

  logic        d2_imem_req;
  logic [7:0]  d2_imem_addr;
  logic [8:0]  d2_ir;
  logic        d2_dmem_req;
  logic        d2_dmem_we;
  logic        d2_rf_we;
  logic [7:0]  d2_pc;
  logic        d2_busy;
  logic [3:0]  d2_retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .dec_write_rf (dec_write_rf),
    .dec_jump_en  (dec_jump_en),
    .dec_mem_sel  (dec_mem_sel),
    .alu_zero     (alu_zero),
    .jump_target  (jump_target),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (rf_we),
    .pc           (pc),
    .busy         (busy),
    .retired      (retired)
  );

  cpu_sequencer #(.CNT_W(4)) dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem_req     (d2_imem_req),
    .imem_addr    (d2_imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ir           (d2_ir),
    .dec_write_rf (dec_write_rf),
    .dec_jump_en  (dec_jump_en),
    .dec_mem_sel  (dec_mem_sel),
    .alu_zero     (alu_zero),
    .jump_target  (jump_target),
    .dmem_req     (d2_dmem_req),
    .dmem_we      (d2_dmem_we),
    .dmem_ack     (dmem_ack),
    .rf_we        (d2_rf_we),
    .pc           (d2_pc),
    .busy         (d2_busy),
    .retired      (d2_retired)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_instr(input logic [8:0] word,
                           input logic wrf, input logic jmp,
                           input logic msel, input logic z,
                           input logic [7:0] tgt);
    imem_rdata   = word;
    dec_write_rf = wrf;
    dec_jump_en  = jmp;
    dec_mem_sel  = msel;
    alu_zero     = z;
    jump_target  = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    imem_valid = 1'b0;
    dmem_ack = 1'b0;
    set_instr(9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({imem_req, dmem_req, dmem_we, rf_we}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);

    // ADD at pc=0: F/D/E/W, rf_we in cycle 4
    rst_n = 1'b1;
    run = 1'b1;
    imem_valid = 1'b1;
    set_instr(9'h005, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1);
    chk("add_f_req", 32'(imem_req), 32'd1);
    chk("add_f_addr", 32'(imem_addr), 32'd0);
    chk("add_f_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("add_d_ir", 32'(ir), 32'h005);
    chk("add_d_rfwe", 32'(rf_we), 32'd0);
    cyc(1);
    chk("add_e_rfwe", 32'(rf_we), 32'd0);
    cyc(1);
    chk("add_w_rfwe", 32'(rf_we), 32'd1);
    chk("add_w_pc", 32'(pc), 32'd0);
    cyc(1);
    chk("add_done_rfwe", 32'(rf_we), 32'd0);
    chk("add_done_pc", 32'(pc), 32'd1);
    chk("add_done_ret", 32'(retired), 32'd1);

    // JMPZ taken to 0x20
    set_instr(9'h140, 1'b0, 1'b1, 1'b0, 1'b1, 8'h20);
    cyc(2);
    chk("jz1_e_pc", 32'(pc), 32'd1);
    chk("jz1_e_rfwe", 32'(rf_we), 32'd0);
    cyc(1);
    chk("jz1_pc", 32'(pc), 32'h20);
    chk("jz1_ret", 32'(retired), 32'd2);
    chk("jz1_req", 32'(imem_req), 32'd1);

    // JMPZ not taken
    set_instr(9'h140, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77);
    cyc(3);
    chk("jz0_pc", 32'(pc), 32'h21);
    chk("jz0_ret", 32'(retired), 32'd3);

    // SAVE, ack after 3 wait cycles; run dropped mid-MEM
    set_instr(9'h1C0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    dmem_ack = 1'b0;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      chk("save_req", 32'(dmem_req), 32'd1);
      chk("save_we", 32'(dmem_we), 32'd1);
      chk("save_rfwe", 32'(rf_we), 32'd0);
      chk("save_busy", 32'(busy), 32'd1);
      if (i == 1) run = 1'b0;
      if (i == 3) dmem_ack = 1'b1;
      cyc(1);
    end
    chk("save_idle_busy", 32'(busy), 32'd0);
    chk("save_idle_reqs", 32'({imem_req, dmem_req, rf_we}), 32'd0);
    chk("save_pc", 32'(pc), 32'h22);
    chk("save_ret", 32'(retired), 32'd4);
    dmem_ack = 1'b0;
    cyc(1);
    chk("idle_stay", 32'(busy), 32'd0);

    // LOAD, zero-wait
    set_instr(9'h183, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    dmem_ack = 1'b1;
    run = 1'b1;
    cyc(1);
    chk("ld_f_addr", 32'(imem_addr), 32'h22);
    cyc(3);
    chk("ld_m_req", 32'(dmem_req), 32'd1);
    chk("ld_m_we", 32'(dmem_we), 32'd0);
    chk("ld_m_rfwe", 32'(rf_we), 32'd0);
    cyc(1);
    chk("ld_w_rfwe", 32'(rf_we), 32'd1);
    chk("ld_w_dreq", 32'(dmem_req), 32'd0);
    cyc(1);
    chk("ld_rfwe_off", 32'(rf_we), 32'd0);
    chk("ld_pc", 32'(pc), 32'h23);
    chk("ld_ret", 32'(retired), 32'd5);

    // imem_valid held low for 5 cycles
    dmem_ack = 1'b0;
    imem_valid = 1'b0;
    set_instr(9'h1AB, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      chk("fw_req", 32'(imem_req), 32'd1);
      chk("fw_addr", 32'(imem_addr), 32'h23);
      chk("fw_ir", 32'(ir), 32'h183);
      if (i == 5) begin
        imem_valid = 1'b1;
        imem_rdata = 9'h02A;
      end
      cyc(1);
    end
    chk("fw_ir_new", 32'(ir), 32'h02A);
    chk("fw_req_off", 32'(imem_req), 32'd0);
    imem_rdata = 9'h1FF;
    cyc(2);
    chk("fw_ir_hold", 32'(ir), 32'h02A);
    chk("fw_w_rfwe", 32'(rf_we), 32'd1);
    cyc(1);
    chk("fw_pc", 32'(pc), 32'h24);
    chk("fw_ret", 32'(retired), 32'd6);

    // PC wrap: jump to 0xFF, then ADD
    set_instr(9'h140, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    cyc(3);
    chk("wrap_jpc", 32'(pc), 32'hFF);
    set_instr(9'h001, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(4);
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("wrap_ret", 32'(retired), 32'd8);

    // NOP-style op, then reset mid-FETCH
    set_instr(9'h0C0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(3);
    chk("nop_pc", 32'(pc), 32'h01);
    chk("nop_ret", 32'(retired), 32'd9);
    imem_valid = 1'b0;
    chk("mf_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mf_rst_strobes", 32'({imem_req, dmem_req, dmem_we, rf_we, busy}), 32'd0);
    chk("mf_rst_pc", 32'(pc), 32'd0);
    chk("mf_rst_ir", 32'(ir), 32'd0);
    chk("mf_rst_ret", 32'(retired), 32'd0);
    cyc(1);

    // 16 NOPs: narrow counter wraps to 0
    rst_n = 1'b1;
    imem_valid = 1'b1;
    cyc(1 + 16 * 3);
    chk("cnt_pc", 32'(pc), 32'd16);
    chk("cnt_ret", 32'(retired), 32'd16);
    chk("cnt_wrap", 32'(d2_retired), 32'd0);
    chk("d2_pc", 32'(d2_pc), 32'd16);
    chk("d2_fetch", 32'({d2_imem_req, d2_busy, d2_dmem_req,
                         d2_dmem_we, d2_rf_we}), 32'b11000);
    chk("d2_addr_ir", 32'({d2_imem_addr, d2_ir}), 32'({8'd16, 9'h0C0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
